fc_layer: RTL and testbench



---
 rtl/fc_layer_pkg.sv | 30 +++
 rtl/fc_mac.sv | 35 +++
 rtl/fc_layer.sv | 221 ++++++++++++++++++++++
 tb/tb_fc_layer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fc_layer_pkg.sv
// Shared constants for the CNN post-processing stages: DRAM address map,
// Q16.16 format and FSM state/read-tag encodings.
package fc_layer_pkg;

    localparam int unsigned FRAC_BITS  = 16;

    localparam int unsigned PARAM_BASE = 0;
    localparam int unsigned IFMAP_BASE = 65536;
    localparam int unsigned OFMAP_BASE = 131072;

    // Feature-map layout: x stride 1, y stride 32, z stride 1024
    localparam int unsigned Y_SHIFT    = 5;
    localparam int unsigned Z_SHIFT    = 10;

    localparam int unsigned ST_W       = 3;
    localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
    localparam logic [ST_W-1:0] ST_LD   = 3'd1;
    localparam logic [ST_W-1:0] ST_MAC  = 3'd2;
    localparam logic [ST_W-1:0] ST_BIAS = 3'd3;
    localparam logic [ST_W-1:0] ST_ACC  = 3'd4;
    localparam logic [ST_W-1:0] ST_WR   = 3'd5;
    localparam logic [ST_W-1:0] ST_DONE = 3'd6;

    // Tag of the read issued last cycle, i.e. what data_in carries now
    localparam logic [1:0] RD_NONE = 2'd0;
    localparam logic [1:0] RD_W    = 2'd1;
    localparam logic [1:0] RD_X    = 2'd2;
    localparam logic [1:0] RD_B    = 2'd3;

endpackage

// File: rtl/fc_mac.sv
// Q16.16 multiply-accumulate: signed 64-bit product, [47:16] slice,
// wrapping 32-bit accumulator with synchronous clear.
module fc_mac
    import fc_layer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] w,
    input  logic [DATA_WIDTH-1:0] x,
    output logic [DATA_WIDTH-1:0] acc
);

    localparam int unsigned PROD_W = 2 * DATA_WIDTH;

    logic signed [PROD_W-1:0] prod;
    logic [DATA_WIDTH-1:0]    term;

    assign prod = PROD_W'($signed(w)) * PROD_W'($signed(x));
    assign term = DATA_WIDTH'(prod >> FRAC_BITS);

    always_ff @(posedge clk) begin
        if (!srstn) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + term;
        end
    end

endmodule

// File: rtl/fc_layer.sv
// Fully-connected layer: streams weights/activations from DRAM, MACs in Q16.16,
// adds bias, applies ReLU and writes one word per output neuron.
module fc_layer
    import fc_layer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 18,
    parameter int unsigned IN_W       = 5,
    parameter int unsigned IN_H       = 5,
    parameter int unsigned IN_D       = 16,
    parameter int unsigned OUT_LEN    = 10
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  enable,
    input  logic                  dram_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ADDR_WIDTH-1:0] addr_in,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  dram_en_rd,
    output logic                  dram_en_wr,
    output logic                  done
);

    localparam int unsigned IN_LEN = IN_W * IN_H * IN_D;
    localparam int unsigned CW     = 16;

    logic [ST_W-1:0]       state_q, state_nxt;
    logic                  phase_q, phase_nxt;
    logic [ADDR_WIDTH-1:0] i_q, i_nxt;
    logic [CW-1:0]         x_q, x_nxt;
    logic [CW-1:0]         y_q, y_nxt;
    logic [CW-1:0]         z_q, z_nxt;
    logic [CW-1:0]         o_q, o_nxt;
    logic [ADDR_WIDTH-1:0] row_q, row_nxt;
    logic [1:0]            pend_q, pend_nxt;
    logic [DATA_WIDTH-1:0] w_q;

    logic [DATA_WIDTH-1:0] data_out_nxt;
    logic [ADDR_WIDTH-1:0] addr_in_nxt;
    logic [ADDR_WIDTH-1:0] addr_out_nxt;
    logic                  rd_en_nxt;
    logic                  wr_en_nxt;
    logic                  done_nxt;

    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] bias_c;
    logic [DATA_WIDTH-1:0] sum_c;
    logic                  mac_en_c;
    logic                  mac_clr_c;

    assign mac_en_c  = (pend_q == RD_X) && dram_valid;
    assign mac_clr_c = (state_q == ST_LD) || (state_q == ST_ACC);
    assign bias_c    = ((pend_q == RD_B) && dram_valid) ? data_in : '0;
    assign sum_c     = acc + bias_c;

    fc_mac #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mac (
        .clk   (clk),
        .srstn (srstn),
        .clr   (mac_clr_c),
        .en    (mac_en_c),
        .w     (w_q),
        .x     (data_in),
        .acc   (acc)
    );

    // Next-state and counter sequencing
    always_comb begin
        state_nxt = state_q;
        phase_nxt = phase_q;
        i_nxt     = i_q;
        x_nxt     = x_q;
        y_nxt     = y_q;
        z_nxt     = z_q;
        o_nxt     = o_q;
        row_nxt   = row_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_nxt = ST_LD;
                end
            end
            ST_LD: begin
                phase_nxt = 1'b0;
                i_nxt     = '0;
                x_nxt     = '0;
                y_nxt     = '0;
                z_nxt     = '0;
                o_nxt     = '0;
                row_nxt   = ADDR_WIDTH'(PARAM_BASE);
                state_nxt = ST_MAC;
            end
            ST_MAC: begin
                if (!phase_q) begin
                    phase_nxt = 1'b1;
                end else begin
                    phase_nxt = 1'b0;
                    if (i_q == ADDR_WIDTH'(IN_LEN - 1)) begin
                        i_nxt     = '0;
                        x_nxt     = '0;
                        y_nxt     = '0;
                        z_nxt     = '0;
                        state_nxt = ST_BIAS;
                    end else begin
                        i_nxt = i_q + ADDR_WIDTH'(1);
                        if (x_q == CW'(IN_W - 1)) begin
                            x_nxt = '0;
                            if (y_q == CW'(IN_H - 1)) begin
                                y_nxt = '0;
                                z_nxt = z_q + CW'(1);
                            end else begin
                                y_nxt = y_q + CW'(1);
                            end
                        end else begin
                            x_nxt = x_q + CW'(1);
                        end
                    end
                end
            end
            ST_BIAS: state_nxt = ST_ACC;
            ST_ACC:  state_nxt = ST_WR;
            ST_WR: begin
                if (o_q == CW'(OUT_LEN - 1)) begin
                    state_nxt = ST_DONE;
                end else begin
                    o_nxt     = o_q + CW'(1);
                    row_nxt   = row_q + ADDR_WIDTH'(IN_LEN + 1);
                    state_nxt = ST_MAC;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Registered outputs are derived from the next state so they align with it
    always_comb begin
        rd_en_nxt    = 1'b0;
        addr_in_nxt  = '0;
        wr_en_nxt    = 1'b0;
        addr_out_nxt = '0;
        done_nxt     = 1'b0;
        data_out_nxt = data_out;
        pend_nxt     = RD_NONE;
        case (state_nxt)
            ST_MAC: begin
                rd_en_nxt = 1'b1;
                if (phase_nxt) begin
                    addr_in_nxt = ADDR_WIDTH'(IFMAP_BASE)
                                + (ADDR_WIDTH'(z_nxt) << Z_SHIFT)
                                + (ADDR_WIDTH'(y_nxt) << Y_SHIFT)
                                + ADDR_WIDTH'(x_nxt);
                end else begin
                    addr_in_nxt = row_nxt + i_nxt;
                end
            end
            ST_BIAS: begin
                rd_en_nxt   = 1'b1;
                addr_in_nxt = row_nxt + ADDR_WIDTH'(IN_LEN);
            end
            ST_WR: begin
                wr_en_nxt    = 1'b1;
                addr_out_nxt = ADDR_WIDTH'(OFMAP_BASE) + ADDR_WIDTH'(o_nxt);
            end
            ST_DONE: done_nxt = 1'b1;
            default: ;
        endcase
        if (state_q == ST_ACC) begin
            data_out_nxt = sum_c[DATA_WIDTH-1] ? '0 : sum_c;
        end
        if (state_q == ST_MAC) begin
            pend_nxt = phase_q ? RD_X : RD_W;
        end else if (state_q == ST_BIAS) begin
            pend_nxt = RD_B;
        end
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            state_q    <= ST_IDLE;
            phase_q    <= 1'b0;
            i_q        <= '0;
            x_q        <= '0;
            y_q        <= '0;
            z_q        <= '0;
            o_q        <= '0;
            row_q      <= '0;
            pend_q     <= RD_NONE;
            w_q        <= '0;
            data_out   <= '0;
            addr_in    <= '0;
            addr_out   <= '0;
            dram_en_rd <= 1'b0;
            dram_en_wr <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            phase_q    <= phase_nxt;
            i_q        <= i_nxt;
            x_q        <= x_nxt;
            y_q        <= y_nxt;
            z_q        <= z_nxt;
            o_q        <= o_nxt;
            row_q      <= row_nxt;
            pend_q     <= pend_nxt;
            data_out   <= data_out_nxt;
            addr_in    <= addr_in_nxt;
            addr_out   <= addr_out_nxt;
            dram_en_rd <= rd_en_nxt;
            dram_en_wr <= wr_en_nxt;
            done       <= done_nxt;
            if ((pend_q == RD_W) && dram_valid) begin
                w_q <= data_in;
            end
        end
    end

endmodule

// File: tb/tb_fc_layer.sv
// Directed bench for fc_layer with a one-cycle-latency DRAM model.
module tb_fc_layer;

    localparam int DW   = 32;
    localparam int AW   = 18;
    localparam int ILEN = 400;
    localparam int OLEN = 10;
    localparam int ROW  = ILEN + 1;
    localparam int OFM  = 131072;

    logic          clk;
    logic          srstn;
    logic          enable;
    logic          dram_valid;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic [AW-1:0] addr_in;
    logic [AW-1:0] addr_out;
    logic          dram_en_rd;
    logic          dram_en_wr;
    logic          done;

    fc_layer dut (
        .clk        (clk),
        .srstn      (srstn),
        .enable     (enable),
        .dram_valid (dram_valid),
        .data_in    (data_in),
        .data_out   (data_out),
        .addr_in    (addr_in),
        .addr_out   (addr_out),
        .dram_en_rd (dram_en_rd),
        .dram_en_wr (dram_en_wr),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:262143];
    logic [DW-1:0] out_mem [0:OLEN-1];
    int wr_cnt    = 0;
    int base_cnt  = 0;
    int done_cnt  = 0;
    int order_err = 0;
    int proto_err = 0;
    int checks    = 0;
    int errors    = 0;

    // Read data returns one cycle after the strobe
    always @(posedge clk) begin
        if (dram_en_rd) begin
            data_in    <= mem[addr_in];
            dram_valid <= 1'b1;
        end else begin
            data_in    <= '0;
            dram_valid <= 1'b0;
        end
    end

    always @(posedge clk) begin
        int idx;
        if (dram_en_wr) begin
            idx = (wr_cnt - base_cnt) % OLEN;
            if (addr_out != AW'(OFM + idx)) order_err++;
            else out_mem[idx] <= data_out;
            wr_cnt++;
        end
        if (dram_en_wr && dram_en_rd) proto_err++;
        if (!dram_en_rd && addr_in != '0) proto_err++;
        if (!dram_en_wr && addr_out != '0) proto_err++;
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [DW-1:0] wv, input logic [DW-1:0] xv, input logic [DW-1:0] bv);
        for (int o = 0; o < OLEN; o++) begin
            for (int i = 0; i < ILEN; i++) mem[o*ROW + i] = wv;
            mem[o*ROW + ILEN] = bv;
        end
        for (int z = 0; z < 16; z++)
            for (int y = 0; y < 5; y++)
                for (int x = 0; x < 5; x++)
                    mem[65536 + z*1024 + y*32 + x] = xv;
    endtask

    task automatic start_run(input logic hold);
        base_cnt = wr_cnt;
        @(posedge clk); #1 enable = 1'b1;
        @(posedge clk); #1 enable = hold;
    endtask

    // Waits for done from cycle 1; returns the cycle in which it was seen
    task automatic wait_done(output int n);
        n = 1;
        while (done !== 1'b1 && n < 9000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic check_outs(input string tag, input logic [DW-1:0] def, input int sp_o,
                              input logic [DW-1:0] sp_v);
        for (int o = 0; o < OLEN; o++)
            check($sformatf("%s out%0d", tag, o), out_mem[o], (o == sp_o) ? sp_v : def);
    endtask

    task automatic do_run(input string tag, input logic [DW-1:0] def, input int sp_o,
                          input logic [DW-1:0] sp_v);
        int n;
        int d0;
        d0 = done_cnt;
        start_run(1'b0);
        wait_done(n);
        check($sformatf("%s done_cycle", tag), n, 8032);
        @(posedge clk); #1;
        check($sformatf("%s done_width", tag), done, 0);
        check($sformatf("%s done_count", tag), done_cnt - d0, 1);
        check($sformatf("%s writes", tag), wr_cnt - base_cnt, OLEN);
        check_outs(tag, def, sp_o, sp_v);
    endtask

    initial begin
        int n;
        int m;
        int d0;
        srstn  = 1'b0;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset data_out", data_out, 0);
        check("reset ctrl", {addr_in, addr_out, dram_en_rd, dram_en_wr, done}, 0);
        srstn = 1'b1;

        load(32'h0001_0000, 32'h0001_0000, 32'h0);
        do_run("ones", 32'h0190_0000, -1, 32'h0);

        load(32'hFFFF_0000, 32'h0001_0000, 32'h0);
        do_run("relu", 32'h0, -1, 32'h0);

        load(32'h0, 32'h0, 32'h0000_4000);
        mem[68676]     = 32'h0002_0000;
        mem[7*ROW + 89] = 32'h0000_8000;
        do_run("single", 32'h0000_4000, 7, 32'h0001_4000);

        load(32'h0064_0000, 32'h0064_0000, 32'h0);
        do_run("wrap", 32'h0900_0000, -1, 32'h0);

        // Abort in the middle of neuron 3
        d0 = done_cnt;
        start_run(1'b0);
        n = 1;
        while (n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check("abort busy", dram_en_rd, 1);
        srstn = 1'b0;
        @(posedge clk); #1;
        check("abort data_out", data_out, 0);
        check("abort ctrl", {addr_in, addr_out, dram_en_rd, dram_en_wr, done}, 0);
        check("abort writes", wr_cnt - base_cnt, 3);
        repeat (4) @(posedge clk);
        #1 srstn = 1'b1;
        repeat (1000) @(posedge clk);
        #1;
        check("abort no_more_writes", wr_cnt - base_cnt, 3);
        check("abort no_done", done_cnt - d0, 0);

        load(32'h0001_0000, 32'h0001_0000, 32'h0);
        do_run("rerun", 32'h0190_0000, -1, 32'h0);

        // enable held high: back-to-back runs, one done each
        load(32'h0, 32'h0, 32'h0000_4000);
        mem[68676]     = 32'h0002_0000;
        mem[7*ROW + 89] = 32'h0000_8000;
        d0 = done_cnt;
        start_run(1'b1);
        wait_done(n);
        check("hold done1_cycle", n, 8032);
        m = 0;
        do begin
            @(posedge clk); #1;
            m++;
        end while (done !== 1'b1 && m < 9000);
        check("hold done2_gap", m, 8033);
        enable = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("hold done_count", done_cnt - d0, 2);
        check("hold writes", wr_cnt - base_cnt, 2*OLEN);
        check_outs("hold", 32'h0000_4000, 7, 32'h0001_4000);

        check("write order", order_err, 0);
        check("bus protocol", proto_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
